layer_argmax_10_16: RTL and testbench

LAYER_ARGMAX_10_16 -- requirements
Module: layer_argmax_10_16

---
 rtl/layer_pkg.sv | 6 +
 rtl/layer_argmax_10_16.sv | 57 +++++
 tb/tb_layer_argmax_10_16.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
// layer_pkg: state encoding and default vector shape shared by every layer stage.
package layer_pkg;
  localparam int M_DEF = 10;
  localparam int T_DEF = 16;
  typedef enum logic {ACC, OUT} state_t;
endpackage

// File: rtl/layer_argmax_10_16.sv
// layer_argmax_10_16: streaming signed argmax over M-word vectors with a valid/ready result port.
module layer_argmax_10_16
  import layer_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int T    = T_DEF,
  parameter int logM = $clog2(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  input  logic signed [T-1:0] data_in,
  output logic                s_ready,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic [logM-1:0]     idx_out
);
  state_t              state;
  logic [logM-1:0]     cnt, run_idx, nxt_idx;
  logic signed [T-1:0] run_max, nxt_max;
  logic                in_xfer, last, take;
  // Accepting while OUT drains lets the next vector's first word ride the output transfer.
  assign s_ready = reset && (state == ACC || (state == OUT && m_ready));
  assign m_valid = state == OUT;
  assign in_xfer = s_valid && s_ready;
  assign last    = int'(cnt) == M - 1;
  assign take    = cnt == '0 || data_in > run_max;
  assign nxt_max = take ? data_in : run_max;
  assign nxt_idx = take ? cnt : run_idx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACC;
      cnt   <= '0;
    end else if (in_xfer) begin
      cnt   <= last ? '0 : cnt + 1;
      state <= last ? OUT : ACC;
    end else if (m_valid && m_ready) begin
      state <= ACC;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max  <= '0;
      run_idx  <= '0;
      data_out <= '0;
      idx_out  <= '0;
    end else if (in_xfer) begin
      run_max <= nxt_max;
      run_idx <= nxt_idx;
      if (last) begin
        data_out <= nxt_max;
        idx_out  <= nxt_idx;
      end
    end
  end
endmodule

// File: tb/tb_layer_argmax_10_16.sv
// tb_layer_argmax_10_16: directed and randomized checks of the argmax stage against a reference model.
module tb_layer_argmax_10_16;
  logic               clk = 0;
  logic               reset;
  logic               s_valid;
  logic signed [15:0] data_in;
  logic               s_ready;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] data_out;
  logic [3:0]         idx_out;
  int passed = 0;
  int total  = 0;

  layer_argmax_10_16 dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .data_in(data_in), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out), .idx_out(idx_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: largest value, then the first position holding it.
  task automatic ref_max(input int v[10], output int mx, output int ix);
    mx = v[0];
    foreach (v[i]) if (v[i] > mx) mx = v[i];
    ix = -1;
    foreach (v[i]) if (ix < 0 && v[i] == mx) ix = i;
  endtask

  task automatic feed(input int v[10]);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1;
      data_in = 16'(v[i]);
      @(posedge clk); #1;
    end
    s_valid = 0;
  endtask

  task automatic chk_res(input string tag, input int v[10]);
    int mx, ix;
    ref_max(v, mx, ix);
    chk({tag, "_valid"}, int'(m_valid), 1);
    chk({tag, "_data"}, int'(data_out), mx);
    chk({tag, "_idx"}, int'(idx_out), ix);
  endtask

  task automatic consume(input string tag);
    m_ready = 1;
    @(posedge clk); #1;
    chk({tag, "_drained"}, int'(m_valid), 0);
  endtask

  task automatic rand_vec(output int v[10]);
    logic signed [15:0] r;
    bit narrow;
    narrow = $urandom_range(0, 1) == 1;
    for (int i = 0; i < 10; i++) begin
      r = narrow ? 16'($urandom_range(0, 6)) - 16'sd3 : 16'($urandom);
      v[i] = r;
    end
  endtask

  initial begin
    int v[10], w[10];
    reset = 0; s_valid = 0; m_ready = 1; data_in = 0;
    #3;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_idx", int'(idx_out), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    chk("idle_s_ready", int'(s_ready), 1);
    chk("idle_m_valid", int'(m_valid), 0);

    v = '{5, 3, 9, 9, 0, 1, 2, 4, 8, 7};
    feed(v);
    chk_res("pos", v);
    consume("pos");

    v = '{-5, -3, -9, -1, -20, -7, -2, -4, -8, -6};
    feed(v);
    chk_res("neg", v);
    consume("neg");

    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    feed(v);
    chk_res("zero", v);
    consume("zero");

    m_ready = 0;
    v = '{12, -40, 300, 7, 300, -1, 0, 299, 5, 6};
    feed(v);
    chk_res("stall0", v);
    for (int k = 0; k < 5; k++) begin
      s_valid = 1;
      data_in = 16'($urandom);
      @(posedge clk); #1;
      chk_res("stall", v);
      chk("stall_s_ready", int'(s_ready), 0);
    end
    s_valid = 0;
    consume("stall");

    m_ready = 1;
    v = '{1, 100, -3, 100, 4, 5, 6, 7, 8, 9};
    w = '{-7, -7, 2, 3, 40, 5, 41, 41, 0, -100};
    feed(v);
    chk_res("b2b_a", v);
    chk("b2b_s_ready", int'(s_ready), 1);
    feed(w);
    chk_res("b2b_b", w);
    consume("b2b");

    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      data_in = 16'(50 + i);
      @(posedge clk); #1;
    end
    reset = 0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_idx", int'(idx_out), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    s_valid = 0;
    @(posedge clk); #1 reset = 1;
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    feed(v);
    chk_res("after_rst", v);

    m_ready = 0;
    #1 reset = 0;
    #1;
    chk("outrst_m_valid", int'(m_valid), 0);
    @(posedge clk); #1 reset = 1;
    m_ready = 1;
    v = '{-2, 8, 8, 1, 0, 0, 3, -9, 2, 7};
    feed(v);
    chk_res("after_outrst", v);
    consume("after_outrst");

    for (int n = 0; n < 30; n++) begin
      rand_vec(v);
      m_ready = $urandom_range(0, 1) == 1;
      feed(v);
      chk_res("rand", v);
      m_ready = 0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk_res("rand_hold", v);
      end
      consume("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
